// File: rtl/riscv_pkg.sv
// riscv_pkg: shared widths, reset PC, fetch FSM states and register-field positions
package riscv_pkg;
    localparam int XLEN = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_KILL} fetch_state_t;
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory request/response bus
interface fetch_stage_if #(parameter int XLEN = riscv_pkg::XLEN);
    logic            imem_req_valid_o;
    logic            imem_req_ready_i;
    logic [XLEN-1:0] imem_req_addr_o;
    logic            imem_rsp_valid_i;
    logic [31:0]     imem_rsp_data_i;
    modport master (
        output imem_req_valid_o, imem_req_addr_o,
        input  imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i
    );
    modport slave (
        input  imem_req_valid_o, imem_req_addr_o,
        output imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i
    );
endinterface

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry {pc, instr} holding buffer; clear beats write beats read
module fetch_skid_buf
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            wr,
    input  logic [XLEN-1:0] wr_pc,
    input  logic [31:0]     wr_instr,
    input  logic            rd,
    output logic            valid,
    output logic [XLEN-1:0] pc,
    output logic [31:0]     instr
);
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (wr) begin
            valid <= 1'b1;
            pc    <= wr_pc;
            instr <= wr_instr;
        end else if (rd) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: RV32I IF stage with PC, single-outstanding imem fetch FSM and IF/ID register
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int          XLEN     = riscv_pkg::XLEN,
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    fetch_stage_if.master   imem,
    output logic            ifid_valid_o,
    output logic [XLEN-1:0] ifid_pc_o,
    output logic [31:0]     ifid_instr_o,
    output logic [4:0]      ifid_rs1_o,
    output logic [4:0]      ifid_rs2_o
);
    fetch_state_t    state, state_n;
    logic [XLEN-1:0] fetch_pc, req_pc, skid_pc;
    logic [31:0]     skid_instr;
    logic            skid_valid, req_fire, rsp_fire, skid_wr, skid_rd;

    assign imem.imem_req_valid_o = !rst && state == S_REQ && !skid_valid && !redirect_valid_i;
    assign imem.imem_req_addr_o  = fetch_pc;
    assign req_fire = imem.imem_req_valid_o && imem.imem_req_ready_i;
    assign rsp_fire = state == S_WAIT && imem.imem_rsp_valid_i;
    // A live response bypasses the skid only when IF/ID can take it right now
    assign skid_wr  = rsp_fire && !redirect_valid_i && (stall_i || skid_valid);
    assign skid_rd  = !stall_i && skid_valid;

    fetch_skid_buf #(.XLEN(XLEN)) u_skid (
        .clk      (clk),
        .rst      (rst),
        .clear    (redirect_valid_i),
        .wr       (skid_wr),
        .wr_pc    (req_pc),
        .wr_instr (imem.imem_rsp_data_i),
        .rd       (skid_rd),
        .valid    (skid_valid),
        .pc       (skid_pc),
        .instr    (skid_instr)
    );

    always_comb begin
        state_n = state;
        case (state)
            S_REQ:   state_n = req_fire ? S_WAIT : S_REQ;
            S_WAIT:  state_n = imem.imem_rsp_valid_i ? S_REQ : redirect_valid_i ? S_KILL : S_WAIT;
            S_KILL:  state_n = imem.imem_rsp_valid_i ? S_REQ : S_KILL;
            default: state_n = S_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_REQ;
            fetch_pc     <= XLEN'(RESET_PC);
            req_pc       <= '0;
            ifid_valid_o <= 1'b0;
            ifid_pc_o    <= '0;
            ifid_instr_o <= '0;
        end else begin
            state    <= state_n;
            fetch_pc <= redirect_valid_i ? (redirect_pc_i & ~XLEN'(3)) :
                        req_fire ? fetch_pc + XLEN'(4) : fetch_pc;
            if (req_fire)
                req_pc <= fetch_pc;
            if (redirect_valid_i) begin
                ifid_valid_o <= 1'b0;
            end else if (!stall_i) begin
                if (skid_valid) begin
                    ifid_valid_o <= 1'b1;
                    ifid_pc_o    <= skid_pc;
                    ifid_instr_o <= skid_instr;
                end else if (rsp_fire) begin
                    ifid_valid_o <= 1'b1;
                    ifid_pc_o    <= req_pc;
                    ifid_instr_o <= imem.imem_rsp_data_i;
                end else begin
                    ifid_valid_o <= 1'b0;
                end
            end
        end
    end

    // Bubbles report x0 so the hazard unit never stalls on them
    assign ifid_rs1_o = ifid_valid_o ? ifid_instr_o[RS1_LSB +: 5] : 5'd0;
    assign ifid_rs2_o = ifid_valid_o ? ifid_instr_o[RS2_LSB +: 5] : 5'd0;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized fetch traffic against a queue-based IF model, plus directed literal checks
module tb_fetch_stage;
    typedef struct {logic [31:0] pc; logic [31:0] instr;} ent_t;

    logic        clk = 1'b0;
    logic        rst, stall, redir;
    logic [31:0] rpc;
    logic        ifid_v;
    logic [31:0] ifid_pc, ifid_instr;
    logic [4:0]  rs1, rs2;
    int          total = 0, bad = 0;
    int          lat = 1, r = 0;
    logic [31:0] maddr = 0;

    // model state: outstanding fetch 0=none 1=live 2=killed, pending deliveries, IF/ID
    int          m_busy = 0;
    logic [31:0] m_pc = 0, m_req_pc = 0;
    ent_t        m_q[$];
    ent_t        m_if;
    bit          m_if_v = 0, go = 0;

    fetch_stage_if bus();

    fetch_stage dut (
        .clk              (clk),
        .rst              (rst),
        .stall_i          (stall),
        .redirect_valid_i (redir),
        .redirect_pc_i    (rpc),
        .imem             (bus),
        .ifid_valid_o     (ifid_v),
        .ifid_pc_o        (ifid_pc),
        .ifid_instr_o     (ifid_instr),
        .ifid_rs1_o       (rs1),
        .ifid_rs2_o       (rs2)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0135_79BD;
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", n, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_pc = 32'h0; m_busy = 0; m_q.delete(); m_if_v = 0;
        end else if (redir) begin
            m_busy = (m_busy != 0 && !bus.imem_rsp_valid_i) ? 2 : 0;
            m_pc = rpc & ~32'h3;
            m_q.delete();
            m_if_v = 0;
        end else begin
            bit want;
            want = m_busy == 0 && m_q.size() == 0;
            if (m_busy == 1 && bus.imem_rsp_valid_i)
                m_q.push_back('{m_req_pc, bus.imem_rsp_data_i});
            if (m_busy != 0 && bus.imem_rsp_valid_i)
                m_busy = 0;
            else if (want && bus.imem_req_ready_i) begin
                m_busy = 1; m_req_pc = m_pc; m_pc = m_pc + 32'd4;
            end
            if (!stall) begin
                if (m_q.size() != 0) begin
                    m_if = m_q.pop_front(); m_if_v = 1;
                end else
                    m_if_v = 0;
            end
        end
        go = 1;
    end

    always @(negedge clk) begin
        if (go) begin
            chk("req_valid", bus.imem_req_valid_o, !rst && m_busy == 0 && m_q.size() == 0 && !redir);
            chk("req_addr", bus.imem_req_addr_o, m_pc);
            chk("ifid_valid", ifid_v, m_if_v);
            chk("rs1", rs1, m_if_v ? m_if.instr[19:15] : 5'd0);
            chk("rs2", rs2, m_if_v ? m_if.instr[24:20] : 5'd0);
            if (m_if_v) begin
                chk("ifid_pc", ifid_pc, m_if.pc);
                chk("ifid_instr", ifid_instr, m_if.instr);
            end
        end
    end

    // one clock: sample handshake, then advance the memory model after the edge
    task automatic tick();
        logic acc;
        logic [31:0] a;
        @(negedge clk);
        acc = bus.imem_req_valid_o && bus.imem_req_ready_i;
        a = bus.imem_req_addr_o;
        @(posedge clk);
        #1;
        if (acc) begin r = lat; maddr = a; end
        bus.imem_rsp_valid_i = 1'b0;
        bus.imem_rsp_data_i = $urandom;
        if (r > 0) begin
            r--;
            if (r == 0) begin
                bus.imem_rsp_valid_i = 1'b1;
                bus.imem_rsp_data_i = mem_data(maddr);
            end
        end
    endtask

    initial begin
        rst = 1; stall = 0; redir = 0; rpc = 0;
        bus.imem_req_ready_i = 1; bus.imem_rsp_valid_i = 0; bus.imem_rsp_data_i = 0;
        tick();
        rst = 0; #1;
        chk("c0_req_valid", bus.imem_req_valid_o, 1);
        chk("c0_req_addr", bus.imem_req_addr_o, 32'h0);
        chk("c0_ifid_valid", ifid_v, 0);
        tick();
        chk("c1_ifid_valid", ifid_v, 0);
        tick();
        chk("c2_ifid_valid", ifid_v, 1);
        chk("c2_ifid_pc", ifid_pc, 32'h0);
        bus.imem_req_ready_i = 0; #1;
        for (int i = 0; i < 3; i++) begin
            chk("hold_req_valid", bus.imem_req_valid_o, 1);
            chk("hold_req_addr", bus.imem_req_addr_o, 32'h4);
            tick();
        end
        bus.imem_req_ready_i = 1;
        tick(); tick();
        chk("c7_ifid_pc", ifid_pc, 32'h4);
        tick();
        chk("c8_bubble", ifid_v, 0);
        tick();
        chk("c9_ifid_pc", ifid_pc, 32'h8);
        stall = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stall_ifid_pc", ifid_pc, 32'h8);
            chk("stall_ifid_valid", ifid_v, 1);
            chk("stall_no_req", bus.imem_req_valid_o, 0);
        end
        stall = 0;
        tick();
        chk("unstall_ifid_pc", ifid_pc, 32'hC);
        chk("unstall_ifid_instr", ifid_instr, mem_data(32'hC));
        chk("unstall_req_addr", bus.imem_req_addr_o, 32'h10);
        lat = 2;
        tick();
        redir = 1; rpc = 32'h100; #1;
        chk("redir_no_req", bus.imem_req_valid_o, 0);
        tick();
        redir = 0; #1;
        chk("kill_ifid_valid", ifid_v, 0);
        chk("kill_no_req", bus.imem_req_valid_o, 0);
        chk("kill_req_addr", bus.imem_req_addr_o, 32'h100);
        lat = 1;
        tick();
        chk("refetch_req_valid", bus.imem_req_valid_o, 1);
        chk("refetch_req_addr", bus.imem_req_addr_o, 32'h100);
        chk("refetch_ifid_valid", ifid_v, 0);
        tick();
        chk("refetch_wait_valid", ifid_v, 0);
        tick();
        chk("target_ifid_pc", ifid_pc, 32'h100);
        stall = 1;
        tick(); tick();
        chk("skid_full_no_req", bus.imem_req_valid_o, 0);
        chk("skid_full_ifid_pc", ifid_pc, 32'h100);
        redir = 1; rpc = 32'h102;
        tick();
        redir = 0; stall = 0; #1;
        chk("flush_ifid_valid", ifid_v, 0);
        chk("flush_rs1", rs1, 0);
        chk("flush_rs2", rs2, 0);
        chk("flush_req_valid", bus.imem_req_valid_o, 1);
        chk("flush_req_addr", bus.imem_req_addr_o, 32'h100);
        tick(); tick();
        chk("realign_ifid_pc", ifid_pc, 32'h100);
        chk("realign_ifid_instr", ifid_instr, mem_data(32'h100));
        lat = 2;
        tick();
        rst = 1; #1;
        chk("rst_no_req", bus.imem_req_valid_o, 0);
        tick();
        rst = 0; lat = 1; #1;
        chk("post_rst_ifid_valid", ifid_v, 0);
        chk("post_rst_req_valid", bus.imem_req_valid_o, 1);
        chk("post_rst_req_addr", bus.imem_req_addr_o, 32'h0);
        tick();
        chk("stale_ignored", ifid_v, 0);
        tick();
        chk("post_rst_ifid_pc", ifid_pc, 32'h0);
        chk("post_rst_ifid_valid2", ifid_v, 1);
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom % 100) == 0;
            stall = ($urandom % 4) == 0;
            redir = ($urandom % 20) == 0;
            rpc = $urandom;
            bus.imem_req_ready_i = ($urandom % 4) != 0;
            lat = 1 + int'($urandom % 3);
            tick();
        end
        rst = 0; stall = 0; redir = 0;
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
